// File: rtl/sc_fetch_unit.sv
// sc_fetch_unit: PC sequencing and instruction fetch; SC_FETCH_PERF_EN adds retired_count
module sc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        commit,
    input  logic        jump,
    input  logic        branch_eq,
    input  logic        branch_ne,
    input  logic        alu_zero,
    input  logic [25:0] jump_target,
    input  logic [31:0] branch_offset,
    input  logic        undefined_instr,
`ifdef SC_FETCH_PERF_EN
    output logic [31:0] retired_count,
`endif
    output logic        halted
);
    typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;
    state_t state, state_next;
    logic [31:0] pc_next, target, branch_pc;
    logic taken, retire;
    assign pc_plus4    = pc + 32'd4;
    assign imem_req    = state == FETCH;
    assign imem_addr   = pc;
    assign instr_valid = state == EXEC;
    assign halted      = state == HALT;
    always_comb begin
        taken      = (branch_eq & alu_zero) | (branch_ne & ~alu_zero);
        branch_pc  = pc_plus4 + (branch_offset << 2);
        target     = undefined_instr ? pc :
                     jump            ? {pc_plus4[31:28], jump_target, 2'b00} :
                     taken           ? branch_pc : pc_plus4;
        retire     = state == EXEC && commit && !undefined_instr;
        pc_next    = state == EXEC && commit ? target : pc;
        state_next = state == IDLE  ? FETCH :
                     state == FETCH ? (imem_ready ? EXEC : FETCH) :
                     state == EXEC  ? (commit ? (undefined_instr ? HALT : FETCH) : EXEC) : HALT;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pc    <= RESET_PC;
            instr <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (state == FETCH && imem_ready) instr <= imem_rdata;
        end
    end
`ifdef SC_FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) retired_count <= '0;
        else if (retire) retired_count <= retired_count + 32'd1;
    end
`endif
endmodule

// File: doc/sc_fetch_unit.md
Name: sc_fetch_unit

Overview:
- Instruction-fetch and PC-sequencing stage that sits directly upstream of the single-cycle control decoder.
- Holds the architectural PC and fetches each instruction from instruction memory over a ready-handshake.
- Presents each instruction to the decoder and datapath, then computes the next PC from the decoder's jump/branch outputs and the ALU zero flag.
- Enters a sticky halt state when the decoder flags an undefined instruction.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; must be word aligned.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active high
imem_req  output  1  fetch request, held until imem_ready
imem_addr  output  32  fetch address, equals pc while imem_req is high
imem_ready  input  1  instruction memory response valid; sampled only in FETCH
imem_rdata  input  32  instruction word, valid with imem_ready
instr  output  32  captured instruction; opcode = instr[31:26] feeds the decoder
instr_valid  output  1  instr is valid and held stable
pc  output  32  PC of the current instruction
pc_plus4  output  32  pc + 4, modulo 2^32
commit  input  1  datapath completes the current instruction this cycle
jump  input  1  decoder jump
branch_eq  input  1  decoder beq
branch_ne  input  1  decoder bne
alu_zero  input  1  ALU result == 0
jump_target  input  26  instr[25:0] from the datapath
branch_offset  input  32  sign-extended immediate, in words
undefined_instr  input  1  decoder undefined-opcode flag
halted  output  1  core stopped on an undefined instruction

Behaviour:
- Reset (synchronous, rst high at the clock edge):
  - pc = RESET_PC; state = IDLE.
  - instr = 0, instr_valid = 0, imem_req = 0, halted = 0.
  - Applies in any state, including mid-FETCH with a request outstanding. The pending imem response is dropped and never captured.
- States: IDLE, FETCH, EXEC, HALT.
  - IDLE: all outputs inactive; goes to FETCH unconditionally on the next cycle.
  - FETCH: imem_req = 1, imem_addr = pc. When imem_ready = 1: instr <= imem_rdata, go to EXEC. Otherwise stay in FETCH with the request held.
  - EXEC: instr_valid = 1; instr and pc are held stable. imem_req = 0, and imem_ready is ignored. Wait for commit.
  - On commit in EXEC, next PC is chosen by priority:
    1. undefined_instr: pc unchanged, go to HALT.
    2. jump: pc <= {pc_plus4[31:28], jump_target, 2'b00}.
    3. (branch_eq & alu_zero) | (branch_ne & ~alu_zero): pc <= pc_plus4 + (branch_offset << 2), 32-bit wraparound.
    4. Otherwise pc <= pc_plus4.
    - Cases 2-4 go to FETCH.
  - HALT: halted = 1, instr_valid = 0, imem_req = 0. Only rst exits HALT.
- commit outside EXEC is ignored.
- jump/branch/undefined_instr are sampled only on the commit cycle.
- Minimum throughput is 2 cycles per instruction: one FETCH cycle with ready, then one EXEC cycle with commit. Latency from rst release to the first imem_req is 1 cycle.
- pc = 32'hFFFF_FFFC sequencing: pc_plus4 = 0, so the next fetch goes to address 0 (wrap, no error).
- Branch and jump targets are word aligned by construction. The two low bits of pc are always 0.

Optional Feature:
SC_FETCH_PERF_EN
- Defined:
  - Adds output retired_count[31:0].
  - Counts +1 on each commit in EXEC that does not go to HALT.
  - Reset to 0; wraps modulo 2^32; frozen in HALT.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset with RESET_PC = 32'h0000_0040, imem_ready tied 1 -> imem_req on the first cycle after rst falls with imem_addr = 0x40; instr_valid the next cycle; sequential commits produce fetches at 0x44, then 0x48.
- Memory stall: imem_ready low for 3 FETCH cycles -> imem_req and imem_addr held constant for 4 cycles; instr captured only on the ready cycle; instr_valid stays low during the stall.
- pc = 0x0000_1000, commit with branch_eq = 1, alu_zero = 1, branch_offset = 32'hFFFF_FFFE -> next pc = 0x0000_0FFC. Same inputs with alu_zero = 0 -> next pc = 0x0000_1004. bne case with alu_zero = 0 -> taken.
- pc = 0x3000_0010, commit with jump = 1, jump_target = 26'h000_0100 -> next pc = 0x3000_0400. jump and branch_eq both set -> jump wins.
- Commit with undefined_instr = 1 at pc = 0x20 -> halted = 1, pc stays 0x20, no further imem_req. rst -> halted = 0 and fetch restarts at RESET_PC.
- rst asserted in FETCH while imem_ready rises in the same cycle -> instr remains 0, state returns to IDLE, and the next fetch goes to RESET_PC. With SC_FETCH_PERF_EN, retired_count reads 5 after 5 normal commits and 0 after reset.
